// File: rtl/hit_src_pkg.sv
// Shared types and default constants for the hit pulse source and the score counter it feeds.
// The score counter sample period is HOLD_CYCLES_DEFAULT as well.
package hit_src_pkg;

  typedef enum logic {
    StIdle,
    StEmit
  } hit_state_e;

  localparam int unsigned HOLD_CYCLES_DEFAULT     = 2000002;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int unsigned MAX_PENDING_DEFAULT     = 7;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hit_pulse_source_if.sv
// Hit source I/O bundle: raw sensor and control inputs, score-counter drive and status outputs.
// The master side is the pulse source; the slave side is the game logic / sensor.
interface hit_pulse_source_if #(
  parameter int unsigned PendW = 3
);
  logic             raw_hit;
  logic             en;
  logic             clear_drop;
  logic             hit;
  logic             busy;
  logic [PendW-1:0] pending;
  logic             dropped;

  modport master (
    input  raw_hit, en, clear_drop,
    output hit, busy, pending, dropped
  );

  modport slave (
    output raw_hit, en, clear_drop,
    input  hit, busy, pending, dropped
  );
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a stability counter; emits a one-cycle pulse on each
// debounced rising edge of the raw input.
module input_debouncer
  import hit_src_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            clean_q, clean_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced level disagrees; any agreement restarts it.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    rise_d  = 1'b0;
    if (sync2_q != clean_q) begin
      if (cnt_q == CntLast) begin
        clean_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;

endmodule

// File: rtl/hit_pulse_source.sv
// Turns each debounced press into one HOLD_CYCLES-long high window on `hit`, queueing presses
// that arrive mid-emission so back-to-back windows merge into one continuous high.
module hit_pulse_source
  import hit_src_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
  parameter int unsigned MAX_PENDING     = MAX_PENDING_DEFAULT
) (
  input logic                clock,
  input logic                reset,
  hit_pulse_source_if.master bus
);

  localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
  localparam int unsigned PendW = $clog2(MAX_PENDING + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [PendW-1:0] PendMax  = PendW'(MAX_PENDING);

  logic clean, rise;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock(clock),
    .reset(reset),
    .raw  (bus.raw_hit),
    .clean(clean),
    .rise (rise)
  );

  hit_state_e       state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [PendW-1:0] pending_q, pending_d;
  logic             dropped_q, dropped_d;

  logic evt, pend_nz, hold_last, deq, enq, drop_set;

  // rise is only meaningful while the clean level is high.
  assign evt       = rise & clean & bus.en;
  assign pend_nz   = (pending_q != '0);
  assign hold_last = (hold_q == HoldLast);

  // A start (or restart) takes the oldest queued item if any, else the coincident event itself.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    deq     = 1'b0;
    enq     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (evt || pend_nz) begin
          state_d = StEmit;
          hold_d  = '0;
          deq     = pend_nz;
          enq     = evt & pend_nz;
        end
      end
      StEmit: begin
        if (hold_last) begin
          hold_d = '0;
          if (evt || pend_nz) begin
            deq = pend_nz;
            enq = evt & pend_nz;
          end else begin
            state_d = StIdle;
          end
        end else begin
          hold_d = hold_q + HoldW'(1);
          enq    = evt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    drop_set  = 1'b0;
    if (enq && !deq) begin
      if (pending_q == PendMax) begin
        drop_set = 1'b1;
      end else begin
        pending_d = pending_q + PendW'(1);
      end
    end else if (deq && !enq) begin
      pending_d = pending_q - PendW'(1);
    end
    dropped_d = drop_set ? 1'b1 : (bus.clear_drop ? 1'b0 : dropped_q);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      pending_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
    end
  end

  assign bus.hit     = (state_q == StEmit);
  assign bus.busy    = (state_q == StEmit) | pend_nz;
  assign bus.pending = pending_q;
  assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_hit_pulse_source.sv
// Bench for hit_pulse_source: directed scenarios plus a randomized run, all compared against
// a cycle-level reference built from remaining-high-time and backlog counts.
module tb_hit_pulse_source;

  localparam int D = 4;
  localparam int H = 10;
  localparam int M = 3;

  logic clk;
  logic rst_n;

  hit_pulse_source_if #(.PendW(2)) bus ();

  hit_pulse_source #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .MAX_PENDING    (M)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference: raw seen two edges late, clean flips after D disagreeing samples, then a
  // remaining-high countdown and an integer backlog.
  bit m_h1, m_h2, m_clean, m_rise, m_dropped;
  int m_streak, m_backlog, m_remain, m_drops;

  function automatic void model_edge();
    bit syn, ev, new_rise, deq, enq;
    if (!rst_n) begin
      m_h1 = 0; m_h2 = 0; m_clean = 0; m_rise = 0; m_dropped = 0;
      m_streak = 0; m_backlog = 0; m_remain = 0;
      return;
    end
    syn      = m_h2;
    ev       = m_rise && bus.en;
    new_rise = 0;
    if (syn != m_clean) begin
      m_streak++;
      if (m_streak == D) begin
        m_clean  = syn;
        m_streak = 0;
        new_rise = syn;
      end
    end else begin
      m_streak = 0;
    end
    m_h2   = m_h1;
    m_h1   = bus.raw_hit;
    m_rise = new_rise;
    deq = 0;
    enq = 0;
    if (m_remain <= 1) begin
      if (m_backlog > 0) begin
        m_remain = H; deq = 1; enq = ev;
      end else if (ev) begin
        m_remain = H;
      end else begin
        m_remain = 0;
      end
    end else begin
      m_remain--;
      enq = ev;
    end
    if (deq) m_backlog--;
    if (enq) begin
      if (m_backlog == M) begin
        m_dropped = 1;
        m_drops++;
      end else begin
        m_backlog++;
      end
    end else if (bus.clear_drop) begin
      m_dropped = 0;
    end
  endfunction

  logic [4:0] dut_tr[$];
  logic [4:0] mod_tr[$];
  int         first_bad;

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    dut_tr.push_back({bus.hit, bus.busy, bus.pending, bus.dropped});
    mod_tr.push_back({m_remain > 0, (m_remain > 0) || (m_backlog > 0), 2'(m_backlog), m_dropped});
  endtask

  task automatic press(int hi, int lo);
    bus.raw_hit = 1'b1;
    repeat (hi) step();
    bus.raw_hit = 1'b0;
    repeat (lo) step();
  endtask

  task automatic clear_traces();
    dut_tr.delete();
    mod_tr.delete();
  endtask

  function automatic int trace_diffs();
    int n = 0;
    foreach (dut_tr[i]) begin
      if (dut_tr[i] !== mod_tr[i]) begin
        if (n == 0) first_bad = i;
        n++;
      end
    end
    return n;
  endfunction

  function automatic int count_hits();
    int n = 0;
    foreach (dut_tr[i]) if (dut_tr[i][4] === 1'b1) n++;
    return n;
  endfunction

  function automatic int longest_run();
    int best = 0, cur = 0;
    foreach (dut_tr[i]) begin
      cur = (dut_tr[i][4] === 1'b1) ? cur + 1 : 0;
      if (cur > best) best = cur;
    end
    return best;
  endfunction

  function automatic int max_pending();
    int mx = 0;
    foreach (dut_tr[i]) if (int'(dut_tr[i][2:1]) > mx) mx = int'(dut_tr[i][2:1]);
    return mx;
  endfunction

  task automatic test_reset();
    int n;
    clear_traces();
    rst_n = 1'b0;
    repeat (2) step();
    tests += 4;
    if (bus.hit !== 1'b0) begin
      failed++; $display("FAIL reset_hit got %b expected 0", bus.hit);
    end
    if (bus.busy !== 1'b0) begin
      failed++; $display("FAIL reset_busy got %b expected 0", bus.busy);
    end
    if (bus.pending !== 2'd0) begin
      failed++; $display("FAIL reset_pending got %0d expected 0", bus.pending);
    end
    if (bus.dropped !== 1'b0) begin
      failed++; $display("FAIL reset_dropped got %b expected 0", bus.dropped);
    end
    rst_n = 1'b1;
    repeat (3) step();
    n = trace_diffs();
    tests++;
    if (n != 0) begin
      failed++;
      $display("FAIL reset trace: %0d cycles differ, first %0d got %b expected %b",
               n, first_bad, dut_tr[first_bad], mod_tr[first_bad]);
    end
  endtask

  task automatic test_single_press();
    int lat = 0, n;
    clear_traces();
    bus.en = 1'b1;
    repeat (3) step();
    bus.raw_hit = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.hit === 1'b1 && lat == 0) lat = i;
    end
    bus.raw_hit = 1'b0;
    repeat (15) step();
    tests += 4;
    if (lat != 7) begin
      failed++; $display("FAIL single_latency got %0d expected 7", lat);
    end
    if (count_hits() != H) begin
      failed++; $display("FAIL single_high_len got %0d expected %0d", count_hits(), H);
    end
    if (max_pending() != 0) begin
      failed++; $display("FAIL single_pending got %0d expected 0", max_pending());
    end
    n = trace_diffs();
    if (n != 0) begin
      failed++;
      $display("FAIL single trace: %0d cycles differ, first %0d got %b expected %b",
               n, first_bad, dut_tr[first_bad], mod_tr[first_bad]);
    end
  endtask

  task automatic test_glitch();
    int n;
    clear_traces();
    press(3, 12);
    tests += 3;
    if (count_hits() != 0) begin
      failed++; $display("FAIL glitch_hit got %0d high cycles expected 0", count_hits());
    end
    if (bus.busy !== 1'b0) begin
      failed++; $display("FAIL glitch_busy got %b expected 0", bus.busy);
    end
    n = trace_diffs();
    if (n != 0) begin
      failed++;
      $display("FAIL glitch trace: %0d cycles differ, first %0d got %b expected %b",
               n, first_bad, dut_tr[first_bad], mod_tr[first_bad]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_traces();
    repeat (3) press(4, 4);
    repeat (25) step();
    tests += 5;
    if (longest_run() != 3 * H) begin
      failed++; $display("FAIL b2b_run got %0d expected %0d", longest_run(), 3 * H);
    end
    if (count_hits() != 3 * H) begin
      failed++; $display("FAIL b2b_total got %0d expected %0d", count_hits(), 3 * H);
    end
    if (max_pending() != 1) begin
      failed++; $display("FAIL b2b_pending got %0d expected 1", max_pending());
    end
    if (bus.busy !== 1'b0) begin
      failed++; $display("FAIL b2b_busy got %b expected 0", bus.busy);
    end
    n = trace_diffs();
    if (n != 0) begin
      failed++;
      $display("FAIL b2b trace: %0d cycles differ, first %0d got %b expected %b",
               n, first_bad, dut_tr[first_bad], mod_tr[first_bad]);
    end
  endtask

  task automatic test_saturation();
    int n, drops0, accepted;
    clear_traces();
    drops0 = m_drops;
    repeat (24) press(4, 4);
    repeat (60) step();
    accepted = 24 - (m_drops - drops0);
    tests += 5;
    if (max_pending() != M) begin
      failed++; $display("FAIL sat_pending got %0d expected %0d", max_pending(), M);
    end
    if (bus.dropped !== 1'b1) begin
      failed++; $display("FAIL sat_dropped got %b expected 1", bus.dropped);
    end
    if (count_hits() != H * accepted || accepted >= 24) begin
      failed++;
      $display("FAIL sat_total got %0d expected %0d (accepted %0d)", count_hits(), H * accepted,
               accepted);
    end
    if (longest_run() != count_hits()) begin
      failed++; $display("FAIL sat_contig got run %0d expected %0d", longest_run(), count_hits());
    end
    n = trace_diffs();
    if (n != 0) begin
      failed++;
      $display("FAIL sat trace: %0d cycles differ, first %0d got %b expected %b",
               n, first_bad, dut_tr[first_bad], mod_tr[first_bad]);
    end
    bus.clear_drop = 1'b1;
    step();
    bus.clear_drop = 1'b0;
    step();
    tests++;
    if (bus.dropped !== 1'b0) begin
      failed++; $display("FAIL clear_drop got %b expected 0", bus.dropped);
    end
  endtask

  task automatic test_enable();
    int n;
    clear_traces();
    bus.en = 1'b0;
    press(4, 4);
    repeat (10) step();
    tests++;
    if (count_hits() != 0) begin
      failed++; $display("FAIL en_off got %0d high cycles expected 0", count_hits());
    end
    clear_traces();
    bus.en = 1'b1;
    press(4, 4);
    press(4, 4);
    tests++;
    if (bus.pending !== 2'd1) begin
      failed++; $display("FAIL en_pending got %0d expected 1", bus.pending);
    end
    bus.en = 1'b0;
    repeat (30) step();
    tests += 3;
    if (count_hits() != 2 * H || longest_run() != 2 * H) begin
      failed++;
      $display("FAIL en_drain got %0d high (run %0d) expected %0d", count_hits(), longest_run(),
               2 * H);
    end
    if (bus.busy !== 1'b0) begin
      failed++; $display("FAIL en_busy got %b expected 0", bus.busy);
    end
    n = trace_diffs();
    if (n != 0) begin
      failed++;
      $display("FAIL enable trace: %0d cycles differ, first %0d got %b expected %b",
               n, first_bad, dut_tr[first_bad], mod_tr[first_bad]);
    end
    bus.en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n, score = 0;
    bit found = 0;
    clear_traces();
    for (int i = 0; i < 300 && !found; i++) begin
      bus.raw_hit = ((i % 8) < 4);
      step();
      if (m_backlog == 2 && m_remain == H - 4) found = 1;
    end
    tests++;
    if (!found) begin
      failed++; $display("FAIL rstmid_setup got no pending=2 emission expected one within 300");
    end
    bus.raw_hit = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests += 3;
    if (bus.hit !== 1'b0) begin
      failed++; $display("FAIL rstmid_hit got %b expected 0", bus.hit);
    end
    if (bus.pending !== 2'd0) begin
      failed++; $display("FAIL rstmid_pending got %0d expected 0", bus.pending);
    end
    if (bus.busy !== 1'b0) begin
      failed++; $display("FAIL rstmid_busy got %b expected 0", bus.busy);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      if ((i % H) == 0 && bus.hit === 1'b1) score++;
    end
    tests += 2;
    if (score != 0) begin
      failed++; $display("FAIL rstmid_score got %0d extra points expected 0", score);
    end
    n = trace_diffs();
    if (n != 0) begin
      failed++;
      $display("FAIL rstmid trace: %0d cycles differ, first %0d got %b expected %b",
               n, first_bad, dut_tr[first_bad], mod_tr[first_bad]);
    end
  endtask

  task automatic test_random();
    int n, cyc = 0, seg;
    clear_traces();
    bus.en = 1'b1;
    while (cyc < 1500) begin
      seg = $urandom_range(1, 12);
      bus.raw_hit = 1'($urandom_range(0, 1));
      repeat (seg) begin
        if ($urandom_range(0, 19) == 0) bus.en = ~bus.en;
        bus.clear_drop = ($urandom_range(0, 29) == 0);
        rst_n = ($urandom_range(0, 399) != 0);
        step();
        cyc++;
      end
    end
    rst_n = 1'b1;
    bus.clear_drop = 1'b0;
    n = trace_diffs();
    tests++;
    if (n != 0) begin
      failed++;
      $display("FAIL random trace: %0d cycles differ, first %0d got %b expected %b",
               n, first_bad, dut_tr[first_bad], mod_tr[first_bad]);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.raw_hit    = 1'b0;
    bus.en         = 1'b0;
    bus.clear_drop = 1'b0;
    m_drops        = 0;
    test_reset();
    test_single_press();
    test_glitch();
    test_back_to_back();
    test_saturation();
    test_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1000000 expected finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
